// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: free-running 16x baud tick, one-word holding register,
// and a START/DATA/STOP shift FSM driving a registered, idle-high tx line.
module uart_tx_unit #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = 163,
    parameter int DIV_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_full,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // The tick counter must also reach SB_TICK-1 when two stop bits are configured.
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [S_W-1:0]   S_LAST    = S_W'(15);
    localparam logic [S_W-1:0]   STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]   N_LAST    = N_W'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Baud tick generator (free running, never realigned to a frame)
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic             s_tick;

    assign s_tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else if (s_tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [DBIT-1:0]   hold_reg;
    logic              full_reg;
    logic              accept;
    logic              load;

    // Acceptance looks only at the registered flag, so a start in the load
    // cycle is dropped even though the slot is about to free up.
    assign accept = tx_start & ~full_reg;
    assign load   = (state_reg == IDLE) & full_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
            full_reg <= 1'b0;
        end else if (accept) begin
            hold_reg <= din;
            full_reg <= 1'b1;
        end else if (load) begin
            full_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [S_W-1:0]  s_reg, s_next;
    logic [N_W-1:0]  n_reg, n_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            tx_reg, tx_next;
    logic            done_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        done_tick  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (full_reg) begin
                    shift_next = hold_reg;
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next     = '0;
                        shift_next = shift_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        done_tick  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx           = tx_reg;
    assign tx_full      = full_reg;
    assign tx_busy      = (state_reg != IDLE);
    // A reset landing in the final stop tick must not report a completed frame.
    assign tx_done_tick = done_tick & ~reset;

endmodule
